rr_arbiter_hold: RTL and testbench

- N-requester round-robin arbiter with registered one-hot grant.
- Grant is held for a whole transaction and released by consumer ack, requester drop, or optional hold timeout.
- Priority pointer moves to (winner+1) mod N on every release, giving starvation-free fairness.
- Sits between N bus masters and one shared resource; successor to the fixed 4-way ring/priority-encoder arbiter.

---
 rtl/rr_arb_pkg.sv | 22 ++
 rtl/rr_prio_pick.sv | 39 +++
 rtl/rr_arbiter_hold.sv | 120 ++++++++++++
 tb/tb_rr_arbiter_hold.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter family.
package rr_arb_pkg;

    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] lim;
        lim = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
        return (MAX_N'(1) << idx) & lim;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping to 0.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    logic           found;

    // Lower half holds only requests at or above ptr, so a low-to-high
    // scan of the doubled vector naturally wraps past N-1 back to 0.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (IDW'(i) >= ptr);
        end
        dbl = {req, masked};
    end

    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = IDW'(i % N);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter whose registered one-hot grant is held until
// ack, requester drop or an optional hold timeout, with bubble-free handover.
module rr_arbiter_hold
    import rr_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 0,
    localparam int IDW      = idw(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           ack,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout,
    output logic           ack_err
);

    localparam int                 CNT_W     = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit                 HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic           timeout_q, timeout_d;
    logic           ack_err_q, ack_err_d;

    logic [N-1:0]   req_en;
    logic [IDW-1:0] next_ptr, pick_ptr, pick_idx;
    logic           pick_any;
    logic           rel_ack, rel_drop, rel_to, rel;
    logic           grant_new;

    assign req_en   = req & {N{en}};
    assign next_ptr = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
    // On a release the new arbitration must already see the advanced pointer.
    assign pick_ptr = (state_q == GRANT) ? next_ptr : ptr_q;

    rr_prio_pick #(
        .N (N)
    ) u_pick (
        .req (req_en),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign rel_ack  = (state_q == GRANT) && ack;
    assign rel_drop = (state_q == GRANT) && !ack && !req[gnt_id_q];
    assign rel_to   = (state_q == GRANT) && !ack && req[gnt_id_q]
                      && HOLD_EN && (hold_q == HOLD_LAST);
    assign rel      = rel_ack || rel_drop || rel_to;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_id_q  <= '0;
            gnt_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   if (rel && !pick_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        hold_d    = hold_q;
        timeout_d = rel_to;
        ack_err_d = (state_q == IDLE) && ack;
        grant_new = pick_any && ((state_q == IDLE) || rel);

        if ((state_q == GRANT) && rel) begin
            ptr_d    = next_ptr;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
        end else if ((state_q == GRANT) && (hold_q != '1)) begin
            hold_d = hold_q + CNT_W'(1);
        end

        if (grant_new) begin
            gnt_d    = N'(onehot(32'(pick_idx), N));
            gnt_id_d = pick_idx;
            hold_d   = '0;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == GRANT);
    assign timeout = timeout_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: vector table, directed timeout/reset sequences,
// and random traffic against a behavioural round-robin model (MAX_HOLD 0 and 3).
module tb_rr_arbiter_hold;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         ack = 1'b0;
    logic [N-1:0] req = '0;

    logic [N-1:0] gnt0, gnt3;
    logic [1:0]   id0, id3;
    logic         busy0, busy3, to0, to3, ae0, ae3;

    always #5 clk = ~clk;

    rr_arbiter_hold #(.N(N), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .gnt(gnt0), .gnt_id(id0), .busy(busy0), .timeout(to0), .ack_err(ae0)
    );

    rr_arbiter_hold #(.N(N), .MAX_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .gnt(gnt3), .gnt_id(id3), .busy(busy3), .timeout(to3), .ack_err(ae3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: owner index (-1 = idle), pointer, cycles already held.
    int mh[2] = '{0, 3};
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];
    bit m_to[2];
    bit m_ae[2];

    typedef struct {
        int en, req, ack, gnt, id, busy, ae;
    } vec_t;

    vec_t tv[26] = '{
        '{1, 'hF, 0, 'h1, 0, 1, 0},
        '{1, 'hF, 0, 'h1, 0, 1, 0},
        '{1, 'hF, 1, 'h2, 1, 1, 0},
        '{1, 'hF, 0, 'h2, 1, 1, 0},
        '{1, 'hF, 1, 'h4, 2, 1, 0},
        '{1, 'hF, 0, 'h4, 2, 1, 0},
        '{1, 'hF, 1, 'h8, 3, 1, 0},
        '{1, 'hF, 0, 'h8, 3, 1, 0},
        '{1, 'hF, 1, 'h1, 0, 1, 0},
        '{1, 'h0, 1, 'h0, 0, 0, 0},
        '{1, 'h0, 1, 'h0, 0, 0, 1},
        '{1, 'h0, 0, 'h0, 0, 0, 0},
        '{1, 'h2, 0, 'h2, 1, 1, 0},
        '{1, 'h3, 1, 'h1, 0, 1, 0},
        '{1, 'h2, 1, 'h2, 1, 1, 0},
        '{1, 'h6, 1, 'h4, 2, 1, 0},
        '{1, 'hA, 0, 'h8, 3, 1, 0},
        '{1, 'h0, 0, 'h0, 0, 0, 0},
        '{0, 'h1, 0, 'h0, 0, 0, 0},
        '{1, 'h1, 0, 'h1, 0, 1, 0},
        '{0, 'h3, 0, 'h1, 0, 1, 0},
        '{0, 'h3, 1, 'h0, 0, 0, 0},
        '{1, 'h3, 0, 'h2, 1, 1, 0},
        '{1, 'hB, 0, 'h2, 1, 1, 0},
        '{1, 'h9, 1, 'h8, 3, 1, 0},
        '{1, 'h0, 0, 'h0, 0, 0, 0}
    };

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_held[d]  = 0;
            m_to[d]    = 1'b0;
            m_ae[d]    = 1'b0;
        end
    endtask

    task automatic model_step(input bit e, input logic [N-1:0] r, input bit a);
        for (int d = 0; d < 2; d++) begin
            m_to[d] = 1'b0;
            m_ae[d] = 1'b0;
            if (m_owner[d] < 0) begin
                m_ae[d] = a;
                if (e && r != 0) begin
                    m_owner[d] = pick(m_ptr[d], r);
                    m_held[d]  = 0;
                end
            end else begin
                bit expire;
                expire = (mh[d] != 0) && (m_held[d] == mh[d] - 1);
                if (a || !r[m_owner[d]] || expire) begin
                    m_to[d]    = !a && r[m_owner[d]] && expire;
                    m_ptr[d]   = (m_owner[d] + 1) % N;
                    m_owner[d] = (e && r != 0) ? pick(m_ptr[d], r) : -1;
                    m_held[d]  = 0;
                end else begin
                    m_held[d]++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0] g;
            logic [1:0]   id;
            logic         b, t, ae;
            int           eg, eid;
            g  = (d == 0) ? gnt0  : gnt3;
            id = (d == 0) ? id0   : id3;
            b  = (d == 0) ? busy0 : busy3;
            t  = (d == 0) ? to0   : to3;
            ae = (d == 0) ? ae0   : ae3;
            eg  = (m_owner[d] < 0) ? 0 : (1 << m_owner[d]);
            eid = (m_owner[d] < 0) ? 0 : m_owner[d];
            chk($sformatf("mh%0d_gnt", mh[d]),     32'(g),  32'(eg));
            chk($sformatf("mh%0d_gnt_id", mh[d]),  32'(id), 32'(eid));
            chk($sformatf("mh%0d_busy", mh[d]),    32'(b),  32'(m_owner[d] >= 0));
            chk($sformatf("mh%0d_timeout", mh[d]), 32'(t),  32'(m_to[d]));
            chk($sformatf("mh%0d_ack_err", mh[d]), 32'(ae), 32'(m_ae[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step(en, req, ack);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h0);
        check_model();
        rst = 1'b1;

        // Vector table on the MAX_HOLD=0 instance
        for (int i = 0; i < 26; i++) begin
            en  = (tv[i].en != 0);
            req = 4'(tv[i].req);
            ack = (tv[i].ack != 0);
            tick();
            chk($sformatf("tbl%0d_gnt", i),     32'(gnt0),  32'(tv[i].gnt));
            chk($sformatf("tbl%0d_gnt_id", i),  32'(id0),   32'(tv[i].id));
            chk($sformatf("tbl%0d_busy", i),    32'(busy0), 32'(tv[i].busy));
            chk($sformatf("tbl%0d_ack_err", i), 32'(ae0),   32'(tv[i].ae));
            chk($sformatf("tbl%0d_timeout", i), 32'(to0),   32'h0);
        end
        ack = 1'b0;

        // Hold timeout with a sole requester, then timeout colliding with ack
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("to_hold%0d_gnt", c), 32'(gnt3), 32'h1);
            chk($sformatf("to_hold%0d_pulse", c), 32'(to3), 32'h0);
        end
        tick();
        chk("to_fire_pulse", 32'(to3), 32'h1);
        chk("to_fire_regrant", 32'(gnt3), 32'h1);
        chk("to_fire_mh0_pulse", 32'(to0), 32'h0);
        tick();
        chk("to_after_pulse", 32'(to3), 32'h0);
        tick();
        ack = 1'b1;
        tick();
        chk("to_ack_same_pulse", 32'(to3), 32'h0);
        chk("to_ack_same_gnt", 32'(gnt3), 32'h1);
        ack = 1'b0;

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 4'b0100;
        tick();
        chk("arst_pre_gnt", 32'(gnt0), 32'h4);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_gnt0", 32'(gnt0), 32'h0);
        chk("arst_busy0", 32'(busy0), 32'h0);
        chk("arst_gnt3", 32'(gnt3), 32'h0);
        chk("arst_busy3", 32'(busy3), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1000;
        tick();
        chk("arst_post_gnt", 32'(gnt0), 32'h8);
        chk("arst_post_id", 32'(id0), 32'h3);
        req = 4'b0011;
        ack = 1'b1;
        tick();
        chk("arst_ptr0_gnt", 32'(gnt0), 32'h1);
        ack = 1'b0;

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            r = req;
            for (int b = 0; b < N; b++) begin
                if (r[b]) r[b] = ($urandom_range(0, 7) != 0);
                else      r[b] = ($urandom_range(0, 2) == 0);
            end
            req = r;
            en  = ($urandom_range(0, 9) != 0);
            ack = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
